// File: rtl/design_mux_ctrl.sv
// Wishbone-controlled pad multiplexer: routes one of NUM_DESIGNS design buses onto
// the shared pads, with a sequenced quiesce/reset/swap FSM and a small register file.
module design_mux_ctrl #(
  parameter int NUM_DESIGNS  = 8,
  parameter int IO_W         = 33,
  parameter int SEL_W        = 5,
  parameter int QUIESCE_CYC  = 16,
  parameter int RST_HOLD_CYC = 8
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n,
  input  logic                        io_rst_in,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [31:0]                 wbs_dat_i,
  output logic [31:0]                 wbs_dat_o,
  input  logic                        wbs_we_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_stb_i,
  output logic                        wbs_ack_o,
  input  logic [NUM_DESIGNS*IO_W-1:0] design_do,
  input  logic [NUM_DESIGNS*IO_W-1:0] design_oeb,
  output logic [IO_W-1:0]             io_out,
  output logic [IO_W-1:0]             io_oeb,
  output logic [NUM_DESIGNS-1:0]      design_rst,
  output logic [31:0]                 custom_settings,
  output logic                        busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUIESCE = 2'd1,
    S_HOLD    = 2'd2
  } state_e;

  localparam int TMAX = (QUIESCE_CYC > RST_HOLD_CYC) ? QUIESCE_CYC : RST_HOLD_CYC;
  localparam int TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);
  localparam logic [31:0] INFO_WORD = {8'(NUM_DESIGNS), 8'(IO_W), 16'hA5A5};

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [SEL_W-1:0]  active_sel_q, active_sel_d;
  logic [SEL_W-1:0]  pending_sel_q, pending_sel_d;
  logic              override_act_q, override_act_d;
  logic              rst_override_q, rst_override_d;
  logic [31:0]       settings_q, settings_d;
  logic [31:0]       counter_q, counter_d;
  logic [31:0]       dat_q, dat_d;
  logic              req_q, ack_q;

  logic              accept, wr, switch_req, rst_base;
  logic [SEL_W-1:0]  sel_wr;
  logic [31:0]       rd_data, ctrl_rd;

  // Only address bits 23..20 decode; slot 0 never reaches the pads.
  logic unused_ok;
  assign unused_ok = ^{wbs_adr_i[31:24], wbs_adr_i[19:0],
                       design_do[IO_W-1:0], design_oeb[IO_W-1:0]};

  // A request is taken only when neither the capture stage nor the ack stage is busy.
  assign accept     = wbs_cyc_i & wbs_stb_i & ~req_q & ~ack_q;
  assign wr         = accept & wbs_we_i;
  assign sel_wr     = wbs_dat_i[2 +: SEL_W];
  assign busy       = (state_q != S_IDLE);
  assign switch_req = wr & wbs_adr_i[23] & ~busy & (sel_wr != active_sel_q);
  assign rst_base   = override_act_q ? rst_override_q : io_rst_in;

  assign wbs_dat_o       = dat_q;
  assign wbs_ack_o       = ack_q;
  assign custom_settings = settings_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      active_sel_q   <= '0;
      pending_sel_q  <= '0;
      override_act_q <= 1'b0;
      rst_override_q <= 1'b1;
      settings_q     <= '0;
      counter_q      <= '0;
      dat_q          <= '0;
      req_q          <= 1'b0;
      ack_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      active_sel_q   <= active_sel_d;
      pending_sel_q  <= pending_sel_d;
      override_act_q <= override_act_d;
      rst_override_q <= rst_override_d;
      settings_q     <= settings_d;
      counter_q      <= counter_d;
      dat_q          <= dat_d;
      req_q          <= accept;
      ack_q          <= req_q;
    end
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[2*SEL_W+2:0] = {busy, pending_sel_q, active_sel_q, rst_override_q, override_act_q};
    if (wbs_adr_i[23])      rd_data = ctrl_rd;
    else if (wbs_adr_i[22]) rd_data = counter_q;
    else if (wbs_adr_i[21]) rd_data = settings_q;
    else if (wbs_adr_i[20]) rd_data = INFO_WORD;
    else                    rd_data = '1;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    override_act_d = override_act_q;
    rst_override_d = rst_override_q;
    pending_sel_d  = pending_sel_q;
    settings_d     = settings_q;
    counter_d      = counter_q + 32'd1;
    dat_d          = dat_q;
    if (accept) dat_d = rd_data;
    if (wr) begin
      if (wbs_adr_i[23]) begin
        override_act_d = wbs_dat_i[0];
        rst_override_d = wbs_dat_i[1];
        if (switch_req) pending_sel_d = sel_wr;
      end else if (wbs_adr_i[22]) begin
        counter_d = wbs_dat_i;
      end else if (wbs_adr_i[21]) begin
        settings_d = wbs_dat_i;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    active_sel_d = active_sel_q;
    case (state_q)
      S_IDLE: begin
        if (switch_req) begin
          state_d = S_QUIESCE;
          timer_d = TW'(QUIESCE_CYC - 1);
        end
      end
      S_QUIESCE: begin
        if (timer_q == '0) begin
          active_sel_d = pending_sel_q;
          state_d      = S_HOLD;
          timer_d      = TW'(RST_HOLD_CYC - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_HOLD: begin
        if (timer_q == '0) state_d = S_IDLE;
        else               timer_d = timer_q - TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Out-of-range and slot-0 selects match no slot, leaving pads tri-stated and resets asserted.
  always_comb begin
    io_out     = '0;
    io_oeb     = '1;
    design_rst = '1;
    if (!busy) begin
      for (int k = 1; k < NUM_DESIGNS; k++) begin
        if (active_sel_q == SEL_W'(k)) begin
          io_out        = design_do[k*IO_W +: IO_W];
          io_oeb        = design_oeb[k*IO_W +: IO_W];
          design_rst[k] = rst_base;
        end
      end
    end
  end

endmodule

// File: tb/tb_design_mux_ctrl.sv
// Self-checking bench for design_mux_ctrl: timeline-based reference model of the
// switch sequence and register file, randomized pads and Wishbone traffic.
module tb_design_mux_ctrl;
  localparam int N  = 8;
  localparam int W  = 33;
  localparam int SW = 5;
  localparam int Q  = 16;
  localparam int R  = 8;
  localparam logic [31:0] A_CTRL = 32'h0080_0000;
  localparam logic [31:0] A_CNT  = 32'h0040_0000;
  localparam logic [31:0] A_SET  = 32'h0020_0000;
  localparam logic [31:0] A_INFO = 32'h0010_0000;

  logic clk = 1'b0, rst_n = 1'b0, io_rst_in = 1'b0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0, wbs_dat_o;
  logic wbs_we_i = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_ack_o;
  logic [N*W-1:0] design_do = '0, design_oeb = '0;
  logic [W-1:0] io_out, io_oeb;
  logic [N-1:0] design_rst;
  logic [31:0] custom_settings;
  logic busy;

  design_mux_ctrl #(.NUM_DESIGNS(N), .IO_W(W), .SEL_W(SW), .QUIESCE_CYC(Q), .RST_HOLD_CYC(R)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .io_rst_in(io_rst_in),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_ack_o(wbs_ack_o),
    .design_do(design_do), .design_oeb(design_oeb), .io_out(io_out), .io_oeb(io_oeb),
    .design_rst(design_rst), .custom_settings(custom_settings), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int e = 0;
  bit model_on = 0, rand_rst = 0;

  // Model: the switch is a timeline anchored at the accept edge of the request.
  bit sw_valid;
  int sw_start, sw_old, sw_target, pending;
  bit ov_act, rst_ov;
  logic [31:0] settings_m, cnt_base;
  int cnt_edge;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int active_at(int ed);
    if (sw_valid && ed >= sw_start + Q) return sw_target;
    return sw_old;
  endfunction

  function automatic bit busy_at(int ed);
    return sw_valid && ed >= sw_start && ed <= sw_start + Q + R - 1;
  endfunction

  function automatic void model_reset();
    sw_valid = 0; sw_old = 0; sw_start = 0; sw_target = 0; pending = 0;
    ov_act = 0; rst_ov = 1; settings_m = '0; cnt_base = '0;
  endfunction

  // Applies an access accepted at edge a; returns the read data it must produce.
  function automatic logic [31:0] model_access(logic [31:0] adr, bit we, logic [31:0] d, int a);
    int pe = a - 1;
    int s;
    logic [31:0] r = '0;
    if (adr[23]) begin
      r[0] = ov_act; r[1] = rst_ov;
      r[6:2] = 5'(active_at(pe)); r[11:7] = 5'(pending); r[12] = busy_at(pe);
      if (we) begin
        s = int'(d[6:2]);
        if (!busy_at(pe) && s != active_at(pe)) begin
          sw_old = active_at(pe); sw_target = s; sw_start = a; sw_valid = 1; pending = s;
        end
        ov_act = d[0]; rst_ov = d[1];
      end
    end else if (adr[22]) begin
      r = cnt_base + 32'(pe - cnt_edge);
      if (we) begin cnt_base = d; cnt_edge = a; end
    end else if (adr[21]) begin
      r = settings_m;
      if (we) settings_m = d;
    end else if (adr[20]) begin
      r = {8'(N), 8'(W), 16'hA5A5};
    end else begin
      r = '1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < N*W; i++) begin
      design_do[i]  = 1'($urandom_range(0, 1));
      design_oeb[i] = 1'($urandom_range(0, 1));
    end
    if (rand_rst) io_rst_in = 1'($urandom_range(0, 1));
  end

  logic [W-1:0] exp_out, exp_oeb;
  logic [N-1:0] exp_rst;
  int ea;
  bit eb, ack_prev;
  always @(posedge clk) begin
    e++;
    #1;
    if (rst_n && model_on) begin
      ea = active_at(e); eb = busy_at(e);
      exp_out = '0; exp_oeb = '1; exp_rst = '1;
      if (!eb && ea > 0 && ea < N) begin
        exp_out = design_do[ea*W +: W];
        exp_oeb = design_oeb[ea*W +: W];
        exp_rst[ea] = ov_act ? rst_ov : io_rst_in;
      end
      check("busy", busy, eb);
      check("io_out", io_out, exp_out);
      check("io_oeb", io_oeb, exp_oeb);
      check("design_rst", design_rst, exp_rst);
      check("custom_settings", custom_settings, settings_m);
      if (wbs_ack_o) check("ack_single_cycle", ack_prev, 0);
      ack_prev = wbs_ack_o;
    end else begin
      ack_prev = 0;
    end
  end

  task automatic xfer(input logic [31:0] adr, input bit we, input logic [31:0] dat,
                      input bit early, output logic [31:0] rd, output int acc);
    int n = 0;
    logic [31:0] exp;
    @(negedge clk);
    wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = dat; wbs_cyc_i = 1; wbs_stb_i = 1;
    acc = e + 1;
    exp = model_access(adr, we, dat, acc);
    do begin
      @(posedge clk); #1; n++;
      if (early && n == 1) begin wbs_cyc_i = 0; wbs_stb_i = 0; end
    end while (!wbs_ack_o && n < 10);
    check("ack_latency", n, 2);
    rd = wbs_dat_o;
    if (!we) check("read_data", rd, exp);
    @(negedge clk);
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] rd);
    int a;
    xfer(adr, 0, '0, 0, rd, a);
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat, output int a);
    logic [31:0] rd;
    xfer(adr, 1, dat, 0, rd, a);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    check("wait_idle", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_io_out"}, io_out, '0);
    check({tag, "_io_oeb"}, io_oeb, 33'h1_FFFF_FFFF);
    check({tag, "_design_rst"}, design_rst, 8'hFF);
    check({tag, "_ack"}, wbs_ack_o, 0);
    check({tag, "_dat_o"}, wbs_dat_o, '0);
    check({tag, "_settings"}, custom_settings, '0);
  endtask

  initial begin
    logic [31:0] rd, adr, dat;
    int a1, a2, cur, s;

    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1; cnt_edge = e; model_on = 1;

    wb_rd(A_CTRL, rd);          check("ctrl_reset_lit", rd, 32'h2);
    wb_rd(A_INFO, rd);          check("info_lit", rd, 32'h0821A5A5);
    wb_rd(32'h0000_1000, rd);   check("unmapped_lit", rd, 32'hFFFFFFFF);
    wb_wr(A_INFO, 32'h1234_5678, a1);
    wb_rd(A_INFO, rd);          check("info_ro_lit", rd, 32'h0821A5A5);

    xfer(A_SET, 1, 32'hDEADBEEF, 1, rd, a1);
    check("settings_out_lit", custom_settings, 32'hDEADBEEF);
    wb_rd(A_SET, rd);           check("settings_rd_lit", rd, 32'hDEADBEEF);

    wb_wr(A_CNT, 32'hFFFF_FFFE, a1);
    wb_rd(A_CNT, rd);           check("cnt_wrap_lit", rd, 32'h0);
    wb_rd(A_CNT, rd);           check("cnt_elapsed_lit", rd, 32'h3);

    // Switch to slot 3, then a select write while busy that must be ignored.
    wb_wr(A_CTRL, 32'h0C, a1);
    wb_wr(A_CTRL, 32'h16, a2);
    check("busy_mid_lit", busy, 1);
    wait_idle();
    check("busy_len_lit", e - a1, Q + R);
    check("rst_after_sw_lit", design_rst, 8'hF7);
    wb_rd(A_CTRL, rd);          check("ctrl_after_sw_lit", rd, 32'h18E);

    // Slot 0, then back to 3 with an override written mid-switch.
    io_rst_in = 1;
    wb_wr(A_CTRL, 32'h02, a1);
    wait_idle();
    check("slot0_oeb_lit", io_oeb, 33'h1_FFFF_FFFF);
    check("slot0_rst_lit", design_rst, 8'hFF);
    wb_wr(A_CTRL, 32'h0E, a1);
    wb_wr(A_CTRL, 32'h15, a2);
    wait_idle();
    check("override_rst_lit", design_rst, 8'hF7);
    wb_rd(A_CTRL, rd);          check("ctrl_override_lit", rd, 32'h18D);

    // Out-of-range select.
    wb_wr(A_CTRL, 32'h25, a1);
    wait_idle();
    check("oor_rst_lit", design_rst, 8'hFF);
    check("oor_out_lit", io_out, '0);

    rand_rst = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: adr = A_CTRL;
        1: adr = A_CNT;
        2: adr = A_SET;
        3: adr = A_INFO;
        4: adr = A_CTRL | A_SET | 32'(($urandom_range(0, 1)) << 22);
        default: adr = $urandom & 32'hFF0F_FFFF;
      endcase
      dat = $urandom;
      xfer(adr, 1'($urandom_range(0, 1)), dat, 1'($urandom_range(0, 1)), rd, a1);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    rand_rst = 0;

    // Asynchronous reset during QUIESCE.
    wait_idle();
    cur = active_at(e);
    s = (cur == 2) ? 4 : 2;
    wb_wr(A_CTRL, 32'(s << 2) | 32'h2, a1);
    repeat (4) @(negedge clk);
    check("busy_before_rst_lit", busy, 1);
    #2 rst_n = 0;
    #1 check_reset_outputs("midrst");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1; cnt_edge = e;
    wb_rd(A_CTRL, rd);          check("ctrl_post_rst_lit", rd, 32'h2);
    repeat (30) @(negedge clk);
    check("no_switch_post_rst_lit", design_rst, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
